// File: rtl/stream_acc_pkg.sv
// Shared types and helpers for the stream block accumulator.
// Provides default widths, sum/length typedefs and a saturating add.
package stream_acc_pkg;

    localparam int SUM_W_DEF = 32;
    localparam int LEN_W_DEF = 16;

    typedef logic [SUM_W_DEF-1:0] sum_t;
    typedef logic [LEN_W_DEF-1:0] len_t;

    // Unsigned add clamped to 2^w-1; w must be <= 64.
    function automatic logic [63:0] sat_add(
        input logic [63:0] a,
        input logic [63:0] b,
        input int unsigned w
    );
        logic [64:0] s;
        logic [64:0] lim;
        s   = {1'b0, a} + {1'b0, b};
        lim = (65'd1 << w) - 65'd1;
        return (s > lim) ? lim[63:0] : s[63:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered occupancy count.
// Ports: push/push_data write, pop/pop_data read (head, 0 when empty),
// count/full/empty status. Push while full is accepted only with pop.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Power-of-two depth: pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/stream_block_accumulator.sv
// Sums each group of cfg_group_len input samples and queues one sum per
// group in an output FIFO; flush emits a partial group early.
// Ports: clk, reset (sync, active-high); cfg_group_len, flush;
// in_data/in_valid/in_ready sample stream; out_data/out_valid/out_ready
// result stream; busy = partial group in progress.
// Build option: define STREAM_ACC_SATURATE_EN to clamp sums at 2^SUM_W-1
// instead of wrapping.
module stream_block_accumulator
    import stream_acc_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int SUM_W     = SUM_W_DEF,
    parameter int LEN_W     = LEN_W_DEF,
    parameter int OUT_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [LEN_W-1:0]  cfg_group_len,
    input  logic              flush,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [SUM_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    localparam int CNT_W = $clog2(OUT_DEPTH) + 1;

    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_eff;
    logic [LEN_W-1:0] len_cur;
    logic [SUM_W-1:0] acc;
    logic [SUM_W-1:0] acc_nxt;
    logic [SUM_W-1:0] push_data;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             flush_pend;
    logic             flush_req;
    logic             accept;
    logic             pop;
    logic             push;
    logic             last;
    logic             room;
    logic             partial;

    assign len_eff = (cfg_group_len == '0) ? LEN_W'(1) : cfg_group_len;
    // First sample of a group uses the live config, later ones the latch.
    assign len_cur = (cnt == '0) ? len_eff : len_q;
    assign last    = (cnt == len_cur - LEN_W'(1));
    assign partial = (cnt != '0);

`ifdef STREAM_ACC_SATURATE_EN
    // Unsigned adds never decrease, so a clamped acc stays clamped
    // for the rest of the group.
    assign acc_nxt = SUM_W'(sat_add(64'(acc), 64'(in_data), SUM_W));
`else
    assign acc_nxt = acc + SUM_W'(in_data);
`endif

    // A pending flush blocks new samples so the partial sum stays intact.
    assign in_ready  = ~reset & ~fifo_full & ~flush_pend;
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign flush_req = flush | flush_pend;
    assign room      = ~fifo_full | pop;
    assign push_data = accept ? acc_nxt : acc;
    assign push      = (accept & (last | flush))
                     | (~accept & flush_req & partial & room);
    assign busy      = partial;
    assign out_valid = ~fifo_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc        <= '0;
            cnt        <= '0;
            len_q      <= LEN_W'(1);
            flush_pend <= 1'b0;
        end else if (accept) begin
            if (cnt == '0) begin
                len_q <= len_eff;
            end
            if (last | flush) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= acc_nxt;
                cnt <= cnt + LEN_W'(1);
            end
            flush_pend <= 1'b0;
        end else if (flush_req & partial) begin
            if (room) begin
                acc        <= '0;
                cnt        <= '0;
                flush_pend <= 1'b0;
            end else begin
                flush_pend <= 1'b1;
            end
        end else begin
            flush_pend <= 1'b0;
        end
    end

    sync_fifo #(
        .DEPTH (OUT_DEPTH),
        .WIDTH (SUM_W)
    ) u_out_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (out_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_stream_block_accumulator.sv
// Testbench for stream_block_accumulator: table vectors, directed
// sequences and random traffic checked against a group-sum model.
module tb_stream_block_accumulator;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cfg_group_len;
    logic        flush;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    logic [15:0] s8_len;
    logic        s8_flush;
    logic [7:0]  s8_in_data;
    logic        s8_in_valid;
    logic        s8_in_ready;
    logic [7:0]  s8_out_data;
    logic        s8_out_valid;
    logic        s8_out_ready;
    logic        s8_busy;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q[$];
    logic [31:0] got[$];
    int          m_cnt = 0;
    int          m_len = 1;
    logic [63:0] m_tot = 0;

    always #5 clk = ~clk;

    stream_block_accumulator dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_group_len (cfg_group_len),
        .flush         (flush),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .busy          (busy)
    );

    stream_block_accumulator #(
        .DATA_W (8),
        .SUM_W  (8)
    ) dut8 (
        .clk           (clk),
        .reset         (reset),
        .cfg_group_len (s8_len),
        .flush         (s8_flush),
        .in_data       (s8_in_data),
        .in_valid      (s8_in_valid),
        .in_ready      (s8_in_ready),
        .out_data      (s8_out_data),
        .out_valid     (s8_out_valid),
        .out_ready     (s8_out_ready),
        .busy          (s8_busy)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] fold(input logic [63:0] t);
`ifdef STREAM_ACC_SATURATE_EN
        return (t > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : t[31:0];
`else
        return t[31:0];
`endif
    endfunction

    task automatic model_push();
        exp_q.push_back(fold(m_tot));
        m_tot = 0;
        m_cnt = 0;
    endtask

    // Reference: a group is the samples accepted since the last emit;
    // its result is their arithmetic total reduced to 32 bits.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            m_cnt = 0;
            m_tot = 0;
        end else begin
            if (out_valid && out_ready) begin
                got.push_back(out_data);
                if (exp_q.size() == 0)
                    chk("pop_without_expected", 1, 0);
                else
                    chk("pop_data", 64'(out_data), 64'(exp_q.pop_front()));
            end
            if (in_valid && in_ready) begin
                if (m_cnt == 0)
                    m_len = (cfg_group_len == 0) ? 1 : int'(cfg_group_len);
                m_tot = m_tot + 64'(in_data);
                m_cnt++;
                if (m_cnt == m_len || flush)
                    model_push();
            end else if (flush && m_cnt != 0) begin
                model_push();
            end
        end
    end

    task automatic send(input logic [31:0] d);
        bit ok;
        ok = 0;
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic drain(input string nm);
        bit done;
        done = 0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !out_valid) begin
                done = 1;
                break;
            end
        end
        chk(nm, 64'(done), 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic [15:0] len;
        logic        fl;
        logic        ordy;
        logic        e_ov;
        logic [31:0] e_od;
        logic        e_busy;
    } vec_t;

    vec_t tbl[13];

    initial begin
        // len 3 group (cfg changes mid-group), len 2 group, then a
        // flushed partial group of 4x5 and a flush on an empty group.
        tbl[0]  = '{1'b1, 32'd1, 16'd3,  1'b0, 1'b1, 1'b0, 32'd0,  1'b1};
        tbl[1]  = '{1'b1, 32'd2, 16'd2,  1'b0, 1'b1, 1'b0, 32'd0,  1'b1};
        tbl[2]  = '{1'b1, 32'd3, 16'd2,  1'b0, 1'b1, 1'b1, 32'd6,  1'b0};
        tbl[3]  = '{1'b1, 32'd4, 16'd2,  1'b0, 1'b1, 1'b0, 32'd0,  1'b1};
        tbl[4]  = '{1'b1, 32'd5, 16'd2,  1'b0, 1'b1, 1'b1, 32'd9,  1'b0};
        tbl[5]  = '{1'b0, 32'd0, 16'd10, 1'b0, 1'b0, 1'b1, 32'd9,  1'b0};
        tbl[6]  = '{1'b1, 32'd5, 16'd10, 1'b0, 1'b0, 1'b1, 32'd9,  1'b1};
        tbl[7]  = '{1'b1, 32'd5, 16'd10, 1'b0, 1'b0, 1'b1, 32'd9,  1'b1};
        tbl[8]  = '{1'b1, 32'd5, 16'd10, 1'b0, 1'b0, 1'b1, 32'd9,  1'b1};
        tbl[9]  = '{1'b1, 32'd5, 16'd10, 1'b0, 1'b0, 1'b1, 32'd9,  1'b1};
        tbl[10] = '{1'b0, 32'd0, 16'd10, 1'b1, 1'b1, 1'b1, 32'd20, 1'b0};
        tbl[11] = '{1'b0, 32'd0, 16'd10, 1'b1, 1'b1, 1'b0, 32'd0,  1'b0};
        tbl[12] = '{1'b0, 32'd0, 16'd10, 1'b0, 1'b1, 1'b0, 32'd0,  1'b0};

        reset = 1'b1;
        cfg_group_len = 16'd3;
        flush = 1'b0;
        in_data = '0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        s8_len = 16'd2;
        s8_flush = 1'b0;
        s8_in_data = '0;
        s8_in_valid = 1'b0;
        s8_out_ready = 1'b0;

        @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 0);
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_out_data", 64'(out_data), 0);
        chk("rst_busy", 64'(busy), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_in_ready", 64'(in_ready), 1);

        for (int i = 0; i < 13; i++) begin
            in_valid      = tbl[i].v;
            in_data       = tbl[i].d;
            cfg_group_len = tbl[i].len;
            flush         = tbl[i].fl;
            out_ready     = tbl[i].ordy;
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_out_valid", i), 64'(out_valid),
                64'(tbl[i].e_ov));
            chk($sformatf("tbl%0d_out_data", i), 64'(out_data),
                64'(tbl[i].e_od));
            chk($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].e_busy));
        end
        drain("tbl_drain");

        // Continuous 0..999 in groups of 100.
        got.delete();
        cfg_group_len = 16'd100;
        out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) send(32'(i));
        drain("t1_drain");
        chk("t1_count", 64'(got.size()), 10);
        chk("t1_first", 64'(got[0]), 4950);
        chk("t1_last", 64'(got[9]), 94950);

        // Same stream with the consumer stalled.
        got.delete();
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) send(32'(i));
                in_valid = 1'b0;
            end
            begin
                repeat (1500) @(posedge clk);
                #1;
                chk("t2_stalled_in_ready", 64'(in_ready), 0);
                chk("t2_stalled_out_valid", 64'(out_valid), 1);
                chk("t2_head_held", 64'(out_data), 4950);
                repeat (500) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("t2_drain");
        chk("t2_count", 64'(got.size()), 10);
        chk("t2_last", 64'(got[9]), 94950);

        // Reset mid-group discards the partial sum.
        got.delete();
        cfg_group_len = 16'd100;
        for (int i = 0; i < 50; i++) send(32'd7);
        in_valid = 1'b0;
        chk("t5_busy_mid", 64'(busy), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_rst_in_ready", 64'(in_ready), 0);
        chk("t5_rst_busy", 64'(busy), 0);
        chk("t5_rst_out_valid", 64'(out_valid), 0);
        reset = 1'b0;
        for (int i = 0; i < 100; i++) send(32'(i));
        drain("t5_drain");
        chk("t5_count", 64'(got.size()), 1);
        chk("t5_sum", 64'(got[0]), 4950);

        // Random traffic, lengths 0..5, random flush and backpressure.
        for (int i = 0; i < 3000; i++) begin
            in_valid      = ($urandom_range(0, 3) != 0);
            in_data       = $urandom;
            cfg_group_len = 16'($urandom_range(0, 5));
            flush         = ($urandom_range(0, 15) == 0);
            out_ready     = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        flush = 1'b1;
        @(posedge clk);
        #1;
        drain("rand_drain");

        // Narrow 8-bit instance: 200 + 100.
        s8_out_ready = 1'b0;
        s8_in_valid = 1'b1;
        s8_in_data = 8'd200;
        @(posedge clk);
        #1;
        s8_in_data = 8'd100;
        @(posedge clk);
        #1;
        s8_in_valid = 1'b0;
        chk("t6_valid", 64'(s8_out_valid), 1);
`ifdef STREAM_ACC_SATURATE_EN
        chk("t6_sum", 64'(s8_out_data), 255);
`else
        chk("t6_sum", 64'(s8_out_data), 44);
`endif
        s8_out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_popped", 64'(s8_out_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
